// File: rtl/ucsbece154b_bp_update_ctrl.sv
// ucsbece154b_bp_update_ctrl
//
// Owns the branch predictor's BTB and PHT write ports. It clears both
// tables with a one-entry-per-cycle sweep after reset and on a flush
// request. It queues resolved branch/jump updates from Execute and writes
// them to the tables at one per cycle. While a sweep runs, busy_o tells
// the fetch-side predictor that table contents are invalid, so fetch
// must predict not-taken.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   upd_*_i               resolved control-flow update from Execute
//   flush_i               request a full table clear (honoured in RUN only)
//   upd_ready_o           queue not full (registered)
//   overflow_o            one-cycle pulse when an update was dropped
//   busy_o                sweep in progress
//   btb_*_o               BTB write port (strobe, index, tag, target, valid, jump)
//   pht_*_o               PHT write port (strobe, index, counter)
module ucsbece154b_bp_update_ctrl #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int QDEPTH          = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    upd_valid_i,
    input  logic [31:0]                             upd_pc_i,
    input  logic [31:0]                             upd_target_i,
    input  logic                                    upd_taken_i,
    input  logic                                    upd_is_jump_i,
    input  logic [1:0]                              upd_ctr_i,
    input  logic [NUM_GHR_BITS-1:0]                 upd_pht_idx_i,
    input  logic                                    flush_i,
    output logic                                    upd_ready_o,
    output logic                                    overflow_o,
    output logic                                    busy_o,
    output logic                                    btb_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0]      btb_idx_o,
    output logic [30-$clog2(NUM_BTB_ENTRIES)-1:0]   btb_tag_o,
    output logic [31:0]                             btb_target_o,
    output logic                                    btb_valid_o,
    output logic                                    btb_jump_o,
    output logic                                    pht_we_o,
    output logic [NUM_GHR_BITS-1:0]                 pht_idx_o,
    output logic [1:0]                              pht_ctr_o
);

    localparam int IDXB    = $clog2(NUM_BTB_ENTRIES);
    localparam int PHT_N   = 1 << NUM_GHR_BITS;
    localparam int SWEEP_N = (NUM_BTB_ENTRIES > PHT_N) ? NUM_BTB_ENTRIES : PHT_N;
    localparam int SW      = $clog2(SWEEP_N) + 1;
    localparam int QW      = $clog2(QDEPTH);

    localparam logic [SW-1:0] SWEEP_LIM = SW'(SWEEP_N);
    localparam logic [SW-1:0] BTB_LIM   = SW'(NUM_BTB_ENTRIES);
    localparam logic [SW-1:0] PHT_LIM   = SW'(PHT_N);
    localparam logic [QW:0]   QFULL     = (QW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    // PC bits [1:0] are always zero for aligned instructions and are not stored.
    typedef struct packed {
        logic [29:0]             pc_w;
        logic [31:0]             target;
        logic                    taken;
        logic                    is_jump;
        logic [1:0]              ctr;
        logic [NUM_GHR_BITS-1:0] pht_idx;
    } upd_t;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    upd_t          q_mem [QDEPTH];
    logic [QW-1:0] head;
    logic [QW-1:0] tail;
    logic [QW:0]   count;
    logic [QW:0]   count_next;
    state_t        state;
    logic [SW-1:0] sweep_idx;

    logic          enq;
    logic          deq;
    upd_t          head_e;
    upd_t          new_e;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^upd_pc_i[1:0];

    // upd_ready_o mirrors !full of the registered count, so it gates enqueue directly.
    assign enq = upd_valid_i && upd_ready_o;
    // A flush sampled in RUN suppresses that cycle's dequeue.
    assign deq = (state == ST_RUN) && !flush_i && (count != '0);

    assign head_e = q_mem[head];

    always_comb begin
        new_e         = '0;
        new_e.pc_w    = upd_pc_i[31:2];
        new_e.target  = upd_target_i;
        new_e.taken   = upd_taken_i;
        new_e.is_jump = upd_is_jump_i;
        new_e.ctr     = upd_ctr_i;
        new_e.pht_idx = upd_pht_idx_i;
    end

    always_comb begin
        count_next = count;
        if (enq && !deq) begin
            count_next = count + (QW+1)'(1);
        end else if (!enq && deq) begin
            count_next = count - (QW+1)'(1);
        end
    end

    // Queue storage holds data only and needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem[tail] <= new_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_INIT;
            sweep_idx    <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            upd_ready_o  <= 1'b1;
            overflow_o   <= 1'b0;
            busy_o       <= 1'b1;
            btb_we_o     <= 1'b0;
            btb_idx_o    <= '0;
            btb_tag_o    <= '0;
            btb_target_o <= '0;
            btb_valid_o  <= 1'b0;
            btb_jump_o   <= 1'b0;
            pht_we_o     <= 1'b0;
            pht_idx_o    <= '0;
            pht_ctr_o    <= 2'b00;
        end else begin
            if (enq) begin
                tail <= tail + QW'(1);
            end
            if (deq) begin
                head <= head + QW'(1);
            end
            count       <= count_next;
            upd_ready_o <= (count_next != QFULL);
            overflow_o  <= upd_valid_i && !upd_ready_o;

            btb_we_o     <= 1'b0;
            btb_idx_o    <= '0;
            btb_tag_o    <= '0;
            btb_target_o <= '0;
            btb_valid_o  <= 1'b0;
            btb_jump_o   <= 1'b0;
            pht_we_o     <= 1'b0;
            pht_idx_o    <= '0;
            pht_ctr_o    <= 2'b00;

            case (state)
                ST_INIT, ST_FLUSH: begin
                    if (sweep_idx == SWEEP_LIM) begin
                        state     <= ST_RUN;
                        busy_o    <= 1'b0;
                        sweep_idx <= '0;
                    end else begin
                        busy_o <= 1'b1;
                        // The smaller table stops being written once its index range is covered.
                        if (sweep_idx < BTB_LIM) begin
                            btb_we_o  <= 1'b1;
                            btb_idx_o <= sweep_idx[IDXB-1:0];
                        end
                        if (sweep_idx < PHT_LIM) begin
                            pht_we_o  <= 1'b1;
                            pht_idx_o <= sweep_idx[NUM_GHR_BITS-1:0];
                            pht_ctr_o <= 2'b01;
                        end
                        sweep_idx <= sweep_idx + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        state     <= ST_FLUSH;
                        busy_o    <= 1'b1;
                        sweep_idx <= '0;
                    end else if (deq) begin
                        if (head_e.taken) begin
                            btb_we_o     <= 1'b1;
                            btb_idx_o    <= head_e.pc_w[IDXB-1:0];
                            btb_tag_o    <= head_e.pc_w[29:IDXB];
                            btb_target_o <= head_e.target;
                            btb_valid_o  <= 1'b1;
                            btb_jump_o   <= head_e.is_jump;
                        end
                        if (!head_e.is_jump) begin
                            pht_we_o  <= 1'b1;
                            pht_idx_o <= head_e.pht_idx;
                            pht_ctr_o <= head_e.taken ? ctr_inc(head_e.ctr) : ctr_dec(head_e.ctr);
                        end
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    busy_o    <= 1'b1;
                    sweep_idx <= '0;
                end
            endcase
        end
    end

endmodule
